// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, funct3
// encodings and the request legality/alignment check.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // True when funct3 is a valid encoding for the access type and the
    // address is naturally aligned for the access size.
    function automatic logic req_ok(input logic store, input logic [2:0] funct3,
                                    input logic [1:0] off);
        logic legal;
        logic aligned;
        if (store)
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU);
        case (funct3[1:0])
            2'b01:   aligned = ~off[0];
            2'b10:   aligned = (off == 2'b00);
            default: aligned = 1'b1;
        endcase
        return legal && aligned;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store mask/data replication and load extraction with
// sign or zero extension. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        wmask = 4'b1111;
        wdata = st_data;
        case (st_funct3[1:0])
            2'b00: begin
                wmask = 4'b0001 << st_off;
                wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                wmask = 4'b0011 << st_off;
                wdata = {2{st_data[15:0]}};
            end
            default: begin
                wmask = 4'b1111;
                wdata = st_data;
            end
        endcase
    end

    always_comb begin
        shifted = rdata >> {ld_off, 3'b000};
        case (ld_funct3)
            F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   ld_data = {24'd0, shifted[7:0]};
            F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   ld_data = {16'd0, shifted[15:0]};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Multi-cycle load/store unit: accepts one memory op, runs a valid/ready
// data-memory transaction and writes loaded data back to the register file.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [ADDR_WIDTH-1:0] req_rd,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_wen,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wmask,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  busy,
    output logic                  fault
);

    state_t      state;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_off;
    logic [3:0]  st_mask;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    lsu_align u_align (
        .st_funct3 (req_funct3),
        .st_off    (req_addr[1:0]),
        .st_data   (req_wdata),
        .wmask     (st_mask),
        .wdata     (st_wdata),
        .ld_funct3 (ld_funct3),
        .ld_off    (ld_off),
        .rdata     (mem_rdata),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            mem_valid <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            rf_wen    <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            fault     <= 1'b0;
            ld_funct3 <= '0;
            ld_off    <= '0;
        end else begin
            fault  <= 1'b0;
            rf_wen <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (!req_ok(req_store, req_funct3, req_addr[1:0])) begin
                            fault <= 1'b1;
                        end else begin
                            state     <= MEM;
                            req_ready <= 1'b0;
                            busy      <= 1'b1;
                            mem_valid <= 1'b1;
                            mem_wen   <= req_store;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= req_store ? st_wdata : '0;
                            mem_wmask <= req_store ? st_mask : 4'b0000;
                            rf_waddr  <= req_rd;
                            ld_funct3 <= req_funct3;
                            ld_off    <= req_addr[1:0];
                        end
                    end
                end
                MEM: begin
                    // Request fields stay frozen until the memory completes.
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_wen   <= 1'b0;
                        if (mem_wen) begin
                            state     <= IDLE;
                            req_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            state    <= WB;
                            rf_wdata <= ld_data;
                            rf_wen   <= (rf_waddr != '0);
                        end
                    end
                end
                WB: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    mem_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus queues expected memory transactions,
// writebacks and faults; a negedge monitor pops and compares them.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata = 32'd0;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;
    logic        fault;

    lsu #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rdata(mem_rdata),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mem_exp_t;

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } rf_exp_t;

    mem_exp_t mem_q[$];
    rf_exp_t  rf_q[$];
    int       fault_exp = 0;
    int       tests = 0;
    int       fails = 0;
    int       wait_left = 0;
    logic [31:0] rsp_data = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: completes after wait_left stall cycles.
    always @(posedge clk) begin
        #1;
        if (mem_valid && !mem_ready) begin
            if (wait_left == 0) begin
                mem_ready = 1'b1;
                mem_rdata = rsp_data;
            end else begin
                wait_left--;
            end
        end else begin
            mem_ready = 1'b0;
            mem_rdata = 32'd0;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_valid && mem_ready) begin
                if (mem_q.size() == 0) begin
                    check("mem_unexpected", {mem_wen, mem_addr[30:0]}, 32'd0);
                end else begin
                    mem_exp_t e;
                    e = mem_q.pop_front();
                    check("mem_wen", mem_wen, e.wen);
                    check("mem_addr", mem_addr, e.addr);
                    check("mem_wmask", mem_wmask, e.wmask);
                    if (e.wen) check("mem_wdata", mem_wdata, e.wdata);
                end
            end
            if (rf_wen) begin
                if (rf_q.size() == 0) begin
                    check("rf_unexpected", {27'd0, rf_waddr}, 32'hFFFF_FFFF);
                end else begin
                    rf_exp_t r;
                    r = rf_q.pop_front();
                    check("rf_waddr", rf_waddr, r.waddr);
                    check("rf_wdata", rf_wdata, r.wdata);
                end
            end
            if (fault) begin
                check("fault_expected", fault_exp > 0, 1);
                check("fault_no_mem", mem_valid, 0);
                if (fault_exp > 0) fault_exp--;
            end
        end
    end

    task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
        req_valid = 1'b1;
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        int n = 0;
        logic acc;
        drive(st, f3, a, wd, rd);
        do begin
            acc = req_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 100);
        req_valid = 1'b0;
        if (!acc) check("accept_timeout", {31'd0, acc}, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) check("idle_timeout", {31'd0, busy}, 0);
    endtask

    task automatic push_mem(input logic wen, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] m);
        mem_exp_t e;
        e.wen = wen; e.addr = a; e.wdata = wd; e.wmask = m;
        mem_q.push_back(e);
    endtask

    task automatic push_rf(input logic [4:0] rd, input logic [31:0] d);
        rf_exp_t r;
        r.waddr = rd; r.wdata = d;
        rf_q.push_back(r);
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                        input logic [31:0] rdata, input logic [31:0] exp);
        rsp_data = rdata; wait_left = 0;
        push_mem(1'b0, {a[31:2], 2'b00}, 32'd0, 4'b0000);
        if (rd != 5'd0) push_rf(rd, exp);
        issue(1'b0, f3, a, 32'd0, rd);
        wait_idle();
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_wd, input logic [3:0] exp_m);
        wait_left = 0;
        push_mem(1'b1, {a[31:2], 2'b00}, exp_wd, exp_m);
        issue(1'b1, f3, a, wd, 5'd1);
        wait_idle();
    endtask

    task automatic bad(input logic st, input logic [2:0] f3, input logic [31:0] a);
        fault_exp++;
        issue(st, f3, a, 32'h1234_5678, 5'd3);
        #1;
        check("fault_mem_valid", mem_valid, 0);
        check("fault_req_ready", req_ready, 1);
        check("fault_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] snap_addr;
        logic [3:0]  snap_mask;
        logic        snap_wen;

        #23;
        check("rst_req_ready", req_ready, 1);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_mem_wen", mem_wen, 0);
        check("rst_rf_wen", rf_wen, 0);
        check("rst_fault", fault, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_wmask", mem_wmask, 0);
        check("rst_rf_waddr", rf_waddr, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // LW with cycle-accurate latency checks
        rsp_data = 32'hDEAD_BEEF; wait_left = 0;
        push_mem(1'b0, 32'h8000_0004, 32'd0, 4'b0000);
        push_rf(5'd5, 32'hDEAD_BEEF);
        issue(1'b0, 3'b010, 32'h8000_0004, 32'd0, 5'd5);
        #1;
        check("lw_n1_mem_valid", mem_valid, 1);
        check("lw_n1_mem_addr", mem_addr, 32'h8000_0004);
        check("lw_n1_req_ready", req_ready, 0);
        @(posedge clk); #2;
        check("lw_n2_rf_wen", rf_wen, 1);
        check("lw_n2_req_ready", req_ready, 0);
        @(posedge clk); #2;
        check("lw_n3_req_ready", req_ready, 1);
        check("lw_n3_rf_wen", rf_wen, 0);

        load(3'b000, 32'h1000_0003, 5'd6, 32'h80FF_1234, 32'hFFFF_FF80);
        load(3'b100, 32'h1000_0003, 5'd7, 32'h80FF_1234, 32'h0000_0080);
        load(3'b001, 32'h1000_0002, 5'd8, 32'h80FF_1234, 32'hFFFF_80FF);
        load(3'b101, 32'h1000_0002, 5'd9, 32'h80FF_1234, 32'h0000_80FF);
        load(3'b000, 32'h1000_0001, 5'd12, 32'h80FF_1234, 32'h0000_0012);

        // SB with store latency check
        push_mem(1'b1, 32'h2000_0000, 32'hABAB_ABAB, 4'b0010);
        issue(1'b1, 3'b000, 32'h2000_0001, 32'h1234_56AB, 5'd1);
        #1;
        check("sb_n1_mem_valid", mem_valid, 1);
        @(posedge clk); #2;
        check("sb_n2_req_ready", req_ready, 1);
        check("sb_n2_mem_valid", mem_valid, 0);

        store(3'b001, 32'h2000_0002, 32'h0000_BEEF, 32'hBEEF_BEEF, 4'b1100);
        store(3'b010, 32'h2000_0008, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111);

        bad(1'b0, 3'b010, 32'h3000_0002);
        bad(1'b1, 3'b001, 32'h3000_0001);
        bad(1'b0, 3'b011, 32'h3000_0000);
        bad(1'b1, 3'b100, 32'h3000_0000);
        @(posedge clk); #1;

        load(3'b010, 32'h4000_0000, 5'd0, 32'h1111_1111, 32'd0);

        // Wait states with a competing request held by execute
        rsp_data = 32'h5A5A_5A5A; wait_left = 5;
        push_mem(1'b0, 32'h5000_0004, 32'd0, 4'b0000);
        push_rf(5'd10, 32'h5A5A_5A5A);
        push_mem(1'b1, 32'h6000_0000, 32'h0102_0304, 4'b1111);
        issue(1'b0, 3'b010, 32'h5000_0004, 32'd0, 5'd10);
        drive(1'b1, 3'b010, 32'h6000_0000, 32'h0102_0304, 5'd1);
        #1;
        snap_addr = mem_addr; snap_mask = mem_wmask; snap_wen = mem_wen;
        for (int i = 0; i < 5; i++) begin
            check("ws_mem_valid", mem_valid, 1);
            check("ws_mem_ready", mem_ready, 0);
            check("ws_mem_addr", mem_addr, snap_addr);
            check("ws_mem_wmask", mem_wmask, snap_mask);
            check("ws_mem_wen", mem_wen, snap_wen);
            check("ws_req_ready", req_ready, 0);
            @(posedge clk); #2;
        end
        check("ws_addr_value", snap_addr, 32'h5000_0004);
        issue(1'b1, 3'b010, 32'h6000_0000, 32'h0102_0304, 5'd1);
        wait_idle();

        // Reset during MEM
        wait_left = 20;
        issue(1'b0, 3'b010, 32'h7000_0000, 32'd0, 5'd11);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("rmid_mem_valid", mem_valid, 0);
        check("rmid_busy", busy, 0);
        check("rmid_req_ready", req_ready, 1);
        check("rmid_rf_wen", rf_wen, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_left = 0;
        @(posedge clk); #1;
        load(3'b010, 32'h7000_0010, 5'd11, 32'h0BAD_F00D, 32'h0BAD_F00D);

        repeat (4) @(posedge clk);
        #1;
        check("mem_q_drained", mem_q.size(), 0);
        check("rf_q_drained", rf_q.size(), 0);
        check("faults_seen", fault_exp, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
